ledbus_driver: RTL and testbench
================================

Name: ledbus_driver

Overview:
Multi-channel, registered successor to the bus-gated LED output stage. It accepts addressed writes over a simple valid/ready bus and stores a per-channel mode. Each LED channel is driven off, static, blinking, or as a one-shot timed pulse. A global enable gates all outputs without disturbing internal state. The block sits between the bus/decoder logic and the board LED pins.

Parameters:
NUM_LED, 4, number of LED channels (1..16)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2)
PULSE_LEN, 50000000, clock cycles an LED stays lit in pulse mode (>=1)
ADDR_W, $clog2(NUM_LED) (min 1), derived localparam, not overridable

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  global output enable; 0 forces led to all-zero
bus_valid  in  1  write request
bus_ready  out  1  block can accept a write this cycle
bus_addr  in  ADDR_W  target channel index
bus_mode  in  2  channel mode: 00 off, 01 static, 10 blink, 11 pulse
bus_data  in  1  static level; used only in mode 01
led  out  NUM_LED  registered LED drive, bit i = channel i

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state changes on the rising edge of clk.
- Reset values:
  - led = 0; bus_ready = 0 during rst, 1 on the first cycle after rst falls.
  - All channel modes = off; static levels = 0; pulse counters = 0.
  - Blink prescaler = 0; blink_phase = 0.
- Handshake:
  - A write is accepted at an edge where bus_valid && bus_ready.
  - bus_ready drops for exactly one cycle after every accepted write (commit cycle), then returns to 1.
  - Maximum rate is one write per 2 cycles.
  - bus_valid held across the commit cycle is not re-accepted until bus_ready is 1 again.
  - Inputs are sampled only at acceptance.
- Write effect, applied at the acceptance edge E to channel bus_addr:
  - 00: mode = off.
  - 01: mode = static; level = bus_data.
  - 10: mode = blink.
  - 11: mode = pulse; pulse counter loads PULSE_LEN.
- Out-of-range address (bus_addr >= NUM_LED): handshake completes normally, no state changes.
- Blink prescaler:
  - Free-running counter 0..BLINK_DIV-1; at wrap, blink_phase toggles.
  - Runs regardless of en.
  - All blink channels share blink_phase, so they stay in phase.
- Pulse:
  - The counter decrements each cycle while nonzero.
  - Channel value is 1 while counter != 0.
  - When the counter reaches 0 the mode reverts to off.
  - A new pulse write mid-pulse reloads the counter to PULSE_LEN (retrigger).
  - Any other mode write cancels the pulse.
- Channel value per mode: off = 0; static = level; blink = blink_phase; pulse = (counter != 0).
- Output:
  - led[i] <= en & value[i], registered.
  - A write accepted at edge E is visible on led after edge E+1 (1-cycle latency).
  - A pulse is therefore high on led for exactly PULSE_LEN cycles.
  - en deassertion clears led at the next edge; re-assertion restores the current value at the next edge.
- Simultaneous events:
  - Pulse expiry and a write to the same channel on the same edge: the write wins.
  - A blink toggle and a write to blink mode on the same edge: the channel takes the new phase.
- rst mid-pulse or mid-blink: everything returns to reset values on that edge; no residual pulse.

Decomposition:
- Package ledbus_pkg:
  - Mode constants LED_OFF=2'b00, LED_STATIC=2'b01, LED_BLINK=2'b10, LED_PULSE=2'b11.
  - Typedef led_mode_t (2-bit).
- Sub-module ledbus_prescaler (parameter DIV): outputs the toggling phase bit. It is reused by other board-facing blocks.
- Per-channel logic is a generate loop in ledbus_driver, not a separate module.

Test Plan (NUM_LED=4, BLINK_DIV=4, PULSE_LEN=3):
1. Reset/handshake:
   - Stimulus: hold rst for 3 cycles with bus_valid=1.
   - Required: led=0000 and bus_ready=0 throughout rst; first accept on the cycle after rst falls; bus_ready pattern then 1,0,1,0 under continuous valid.
2. Static plus enable gating:
   - Stimulus: en=1; write addr=2, mode=01, data=1.
   - Required: led=0100 one cycle after acceptance.
   - Stimulus: drop en.
   - Required: led=0000 next cycle; led=0100 again one cycle after en returns.
3. Blink:
   - Stimulus: write addr=0 and addr=3 with mode=10.
   - Required: led[0] and led[3] identical, toggling every 4 cycles; led[1] and led[2] stay 0.
4. Pulse and retrigger:
   - Stimulus: write addr=1, mode=11.
   - Required: led[1] high exactly 3 cycles, then 0; channel mode reads back as off (led stays 0).
   - Stimulus: repeat, and rewrite pulse on its 2nd high cycle.
   - Required: 5 total high cycles.
5. Cancel and out-of-range:
   - Stimulus: start a pulse on ch1, then write ch1 mode=00 mid-pulse.
   - Required: led[1]=0 one cycle after acceptance.
   - Stimulus: with NUM_LED=3 build, write addr=3.
   - Required: handshake completes, led unchanged.
6. Reset mid-operation:
   - Stimulus: assert rst during an active pulse and blink.
   - Required: led=0000 after that edge; no pulse after rst release until a new write.

Source files
------------

// File: rtl/ledbus_pkg.sv
// rtl/ledbus_pkg.sv - shared mode encoding for the LED bus driver
package ledbus_pkg;

    typedef enum logic [1:0] {
        LED_OFF    = 2'b00,
        LED_STATIC = 2'b01,
        LED_BLINK  = 2'b10,
        LED_PULSE  = 2'b11
    } led_mode_t;

endpackage

// File: rtl/ledbus_if.sv
// rtl/ledbus_if.sv - valid/ready write bus carrying per-channel mode updates
interface ledbus_if #(
    parameter int NUM_LED = 4
);
    import ledbus_pkg::*;

    localparam int ADDR_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    logic              bus_valid;
    logic              bus_ready;
    logic [ADDR_W-1:0] bus_addr;
    led_mode_t         bus_mode;
    logic              bus_data;

    modport master (
        output bus_valid, bus_addr, bus_mode, bus_data,
        input  bus_ready
    );

    modport slave (
        input  bus_valid, bus_addr, bus_mode, bus_data,
        output bus_ready
    );

endinterface

// File: rtl/ledbus_prescaler.sv
// rtl/ledbus_prescaler.sv - free-running divider producing a phase bit that toggles every DIV cycles
module ledbus_prescaler #(
    parameter int DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic phase
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ledbus_driver.sv
// rtl/ledbus_driver.sv - bus-written multi-channel LED driver with off/static/blink/pulse modes
module ledbus_driver
    import ledbus_pkg::*;
#(
    parameter int NUM_LED   = 4,
    parameter int BLINK_DIV = 25000000,
    parameter int PULSE_LEN = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    ledbus_if.slave            bus,
    output logic [NUM_LED-1:0] led
);

    localparam int ADDR_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam int PCNT_W = $clog2(PULSE_LEN + 1);

    logic               ready_q;
    logic               accept;
    logic               blink_phase;
    logic [NUM_LED-1:0] value;

    assign bus.bus_ready = ready_q;
    assign accept        = bus.bus_valid & ready_q;

    // Ready drops for the commit cycle after every accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ~accept;
        end
    end

    ledbus_prescaler #(
        .DIV(BLINK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .phase(blink_phase)
    );

    for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
        led_mode_t         mode;
        logic              level;
        logic [PCNT_W-1:0] pcnt;
        logic              hit;

        // Out-of-range addresses never match a channel, so they only complete the handshake.
        assign hit = accept && (bus.bus_addr == ADDR_W'(i));

        always_ff @(posedge clk) begin
            if (rst) begin
                mode  <= LED_OFF;
                level <= 1'b0;
                pcnt  <= '0;
            end else if (hit) begin
                mode <= bus.bus_mode;
                pcnt <= (bus.bus_mode == LED_PULSE) ? PCNT_W'(PULSE_LEN) : '0;
                if (bus.bus_mode == LED_STATIC) begin
                    level <= bus.bus_data;
                end
            end else if (pcnt != '0) begin
                pcnt <= pcnt - 1'b1;
                if (pcnt == PCNT_W'(1)) begin
                    mode <= LED_OFF;
                end
            end
        end

        assign value[i] = (mode == LED_STATIC) ? level :
                          (mode == LED_BLINK)  ? blink_phase :
                          (mode == LED_PULSE)  ? (pcnt != '0) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= en ? value : '0;
        end
    end

endmodule

// File: tb/tb_ledbus_driver.sv
// tb/tb_ledbus_driver.sv - randomized and directed checks of ledbus_driver against a timeline model
module tb_ledbus_driver;
    import ledbus_pkg::*;

    localparam int NUM_LED   = 4;
    localparam int BLINK_DIV = 4;
    localparam int PULSE_LEN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [NUM_LED-1:0] led;
    logic [2:0]         led3;

    ledbus_if #(.NUM_LED(NUM_LED)) bus ();
    ledbus_if #(.NUM_LED(3))       bus3 ();

    ledbus_driver #(.NUM_LED(NUM_LED), .BLINK_DIV(BLINK_DIV), .PULSE_LEN(PULSE_LEN)) dut (
        .clk(clk), .rst(rst), .en(en), .bus(bus), .led(led)
    );

    ledbus_driver #(.NUM_LED(3), .BLINK_DIV(BLINK_DIV), .PULSE_LEN(PULSE_LEN)) dut3 (
        .clk(clk), .rst(rst), .en(en), .bus(bus3), .led(led3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: k counts non-reset edges; a pulse written when k==kw is lit while k <= kw+PULSE_LEN.
    int m_mode  [NUM_LED];
    bit m_level [NUM_LED];
    int m_end   [NUM_LED];
    int k;
    logic [NUM_LED-1:0] exp_led;
    bit exp_ready;
    bit last_acc;
    int hi1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit chan_val(input int i, input int ph);
        case (m_mode[i])
            1:       return m_level[i];
            2:       return ph[0];
            3:       return k <= m_end[i];
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        logic [NUM_LED-1:0] nl;
        bit acc;
        int ph;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                m_mode[i] = 0; m_level[i] = 0; m_end[i] = 0;
            end
            k = 0; exp_led = '0; exp_ready = 0; last_acc = 0;
        end else begin
            ph = (k / BLINK_DIV) % 2;
            for (int i = 0; i < NUM_LED; i++) nl[i] = en & chan_val(i, ph);
            acc = bus.bus_valid && exp_ready;
            if (acc && int'(bus.bus_addr) < NUM_LED) begin
                m_mode[bus.bus_addr] = int'(bus.bus_mode);
                m_end[bus.bus_addr]  = k + PULSE_LEN;
                if (bus.bus_mode == LED_STATIC) m_level[bus.bus_addr] = bus.bus_data;
            end
            exp_ready = !acc; last_acc = acc; k++; exp_led = nl;
        end
        #1;
        check("led", 32'(led), 32'(exp_led));
        check("ready", 32'(bus.bus_ready), 32'(exp_ready));
        if (led[1]) hi1++;
    endtask

    task automatic wr(input int a, input int m, input bit d);
        bus.bus_valid = 1'b1;
        bus.bus_addr  = 2'(a);
        bus.bus_mode  = led_mode_t'(2'(m));
        bus.bus_data  = d;
        last_acc = 0;
        for (int n = 0; n < 8 && !last_acc; n++) tick();
        check("wr_accept", 32'(last_acc), 32'd1);
        bus.bus_valid = 1'b0;
    endtask

    initial begin
        bit exp_pat [4] = '{1, 0, 1, 0};
        bus.bus_valid = 1'b1; bus.bus_addr = '0; bus.bus_mode = LED_OFF; bus.bus_data = 1'b0;
        bus3.bus_valid = 1'b0; bus3.bus_addr = '0; bus3.bus_mode = LED_OFF; bus3.bus_data = 1'b0;

        // Reset with valid held, then 1,0,1,0 ready pattern.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_led", 32'(led), 32'd0);
            check("rst_ready", 32'(bus.bus_ready), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ready_pattern", 32'(bus.bus_ready), 32'(exp_pat[i]));
        end
        bus.bus_valid = 1'b0;
        tick();

        // Static plus enable gating.
        en = 1'b1;
        wr(2, 1, 1'b1);
        tick();
        check("static_on", 32'(led), 32'h4);
        en = 1'b0;
        tick();
        check("en_off", 32'(led), 32'h0);
        en = 1'b1;
        tick();
        check("en_back", 32'(led), 32'h4);

        // Blink on channels 0 and 3.
        wr(2, 0, 1'b0);
        wr(0, 2, 1'b0);
        wr(3, 2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("blink_sync", 32'(led[0]), 32'(led[3]));
            check("blink_idle", 32'(led[2:1]), 32'd0);
        end

        // Pulse length and retrigger.
        wr(0, 0, 1'b0);
        wr(3, 0, 1'b0);
        tick();
        hi1 = 0;
        wr(1, 3, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        check("pulse_len", 32'(hi1), 32'd3);
        hi1 = 0;
        wr(1, 3, 1'b0);
        tick();
        wr(1, 3, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("retrigger_len", 32'(hi1), 32'd5);

        // Cancel mid-pulse.
        wr(1, 3, 1'b0);
        tick();
        wr(1, 0, 1'b0);
        tick();
        check("cancel", 32'(led[1]), 32'd0);

        // Out-of-range address on the 3-channel build.
        bus3.bus_valid = 1'b1; bus3.bus_addr = 2'd0; bus3.bus_mode = LED_STATIC; bus3.bus_data = 1'b1;
        tick();
        check("oor_pre_ready", 32'(bus3.bus_ready), 32'd0);
        bus3.bus_valid = 1'b0;
        tick();
        check("oor_pre_led", 32'(led3), 32'd1);
        bus3.bus_valid = 1'b1; bus3.bus_addr = 2'd3; bus3.bus_mode = LED_STATIC; bus3.bus_data = 1'b1;
        tick();
        check("oor_accept", 32'(bus3.bus_ready), 32'd0);
        bus3.bus_valid = 1'b0;
        tick();
        check("oor_ready_back", 32'(bus3.bus_ready), 32'd1);
        check("oor_led", 32'(led3), 32'd1);
        tick();
        check("oor_led_hold", 32'(led3), 32'd1);

        // Reset during active pulse and blink.
        wr(1, 3, 1'b0);
        wr(0, 2, 1'b0);
        rst = 1'b1;
        tick();
        check("rst_mid", 32'(led), 32'd0);
        rst = 1'b0;
        hi1 = 0;
        for (int i = 0; i < 10; i++) tick();
        check("no_residual", 32'(hi1), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 7) != 0);
            bus.bus_valid = 1'($urandom_range(0, 1));
            bus.bus_addr  = 2'($urandom_range(0, 3));
            bus.bus_mode  = led_mode_t'(2'($urandom_range(0, 3)));
            bus.bus_data  = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0;
        bus.bus_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
